// File: rtl/ntt_sched_pkg.sv
// Shared definitions for the NTT stage scheduler: mode encoding, FSM state type
// and the read-to-write pipeline depth helper.
package ntt_sched_pkg;

  localparam logic [1:0] MODE_FWD = 2'd0;
  localparam logic [1:0] MODE_INV = 2'd1;
  localparam logic [1:0] MODE_EW  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  function automatic int pipe_depth(input int rd_lat, input int bfu_lat);
    return rd_lat + bfu_lat;
  endfunction

endpackage

// File: rtl/ntt_stage_scheduler_addr_gen.sv
// Combinational (stage, issue index, mode) -> (a, b, twiddle) mapper for
// Cooley-Tukey forward, Gentleman-Sande inverse and element-wise passes.
module ntt_addr_gen
  import ntt_sched_pkg::*;
#(
  parameter int LOG_N = 10,
  parameter int SW    = 4
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG_N-1:0] k,
  input  logic [1:0]       mode,
  output logic [LOG_N-1:0] a,
  output logic [LOG_N-1:0] b,
  output logic [LOG_N-1:0] tw
);

  localparam int unsigned N = 1 << LOG_N;

  int unsigned s_i, k_i, t, j, i_off, a_i, b_i, tw_i;

  // t is the butterfly span, j the block index and i_off the offset in the block
  always_comb begin
    s_i   = 32'(stage);
    k_i   = 32'(k);
    t     = 0;
    j     = 0;
    i_off = 0;
    a_i   = 0;
    b_i   = 0;
    tw_i  = 0;
    case (mode)
      MODE_FWD: begin
        t     = N >> (s_i + 1);
        j     = k_i >> (LOG_N - 1 - s_i);
        i_off = k_i & (t - 1);
        a_i   = (j << (LOG_N - s_i)) + i_off;
        b_i   = a_i + t;
        tw_i  = (32'd1 << s_i) + j;
      end
      MODE_INV: begin
        t     = 32'd1 << s_i;
        j     = k_i >> s_i;
        i_off = k_i & (t - 1);
        a_i   = (j << (s_i + 1)) + i_off;
        b_i   = a_i + t;
        tw_i  = (N >> (s_i + 1)) + j;
      end
      default: begin
        a_i  = k_i;
        b_i  = k_i;
        tw_i = 0;
      end
    endcase
  end

  assign a  = LOG_N'(a_i);
  assign b  = LOG_N'(b_i);
  assign tw = LOG_N'(tw_i);

endmodule

// File: rtl/ntt_stage_scheduler.sv
// NTT stage scheduler: issues butterfly reads stage by stage and delays the
// addresses to the write port. Optional cycle counter via NTT_SCHED_PERF_CNT_EN.
module ntt_stage_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int LOG_N          = 10,
  parameter int BFU_LATENCY    = 17,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             bfu_forward,
  output logic             bfu_element_wise,
  output logic             wr_en_a,
  output logic             wr_en_b,
  output logic [LOG_N-1:0] wr_addr_a,
`ifdef NTT_SCHED_PERF_CNT_EN
  output logic [LOG_N-1:0] wr_addr_b,
  output logic [31:0]      cycle_count
`else
  output logic [LOG_N-1:0] wr_addr_b
`endif
);

  localparam int N  = 1 << LOG_N;
  localparam int P  = pipe_depth(MEM_RD_LATENCY, BFU_LATENCY);
  localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int DW = (P > 1) ? $clog2(P) : 1;

  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG_N - 1);
  localparam logic [LOG_N-1:0] LAST_K_NTT = LOG_N'(N / 2 - 1);
  localparam logic [LOG_N-1:0] LAST_K_EW  = LOG_N'(N - 1);
  localparam logic [DW-1:0]    LAST_DRAIN = DW'(P - 1);

  state_t           state;
  logic [SW-1:0]    stage;
  logic [LOG_N-1:0] k;
  logic [DW-1:0]    drain_cnt;
  logic [1:0]       op_mode;
  logic             op_ew;
  logic             last_k;
  logic [LOG_N-1:0] gen_a, gen_b, gen_tw;

  logic             dl_v [P];
  logic [LOG_N-1:0] dl_a [P];
  logic [LOG_N-1:0] dl_b [P];

  assign op_ew  = (op_mode == MODE_EW);
  assign last_k = (k == (op_ew ? LAST_K_EW : LAST_K_NTT));

  ntt_addr_gen #(
    .LOG_N (LOG_N),
    .SW    (SW)
  ) u_addr_gen (
    .stage (stage),
    .k     (k),
    .mode  (op_mode),
    .a     (gen_a),
    .b     (gen_b),
    .tw    (gen_tw)
  );

  // Draining exactly P cycles after the last issue lets the next stage read
  // in the cycle right after the previous stage's final write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      stage            <= '0;
      k                <= '0;
      drain_cnt        <= '0;
      op_mode          <= MODE_FWD;
      bfu_forward      <= 1'b0;
      bfu_element_wise <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_mode          <= mode[1] ? MODE_EW : mode;
            bfu_forward      <= (mode == MODE_FWD) || mode[1];
            bfu_element_wise <= mode[1];
            stage            <= '0;
            k                <= '0;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (last_k) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            if (!op_ew && stage != LAST_STAGE) begin
              stage <= stage + 1'b1;
              k     <= '0;
              state <= ST_ISSUE;
            end else begin
              state <= ST_FINISH;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);
  assign rd_en     = (state == ST_ISSUE);
  assign rd_addr_a = rd_en ? gen_a  : '0;
  assign rd_addr_b = rd_en ? gen_b  : '0;
  assign tw_addr   = rd_en ? gen_tw : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < P; i++) begin
        dl_v[i] <= 1'b0;
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else begin
      dl_v[0] <= rd_en;
      dl_a[0] <= rd_addr_a;
      dl_b[0] <= rd_addr_b;
      for (int i = 1; i < P; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  // Element-wise results come back on port b only
  assign wr_en_a   = dl_v[P-1] & ~op_ew;
  assign wr_en_b   = dl_v[P-1];
  assign wr_addr_a = dl_a[P-1];
  assign wr_addr_b = dl_b[P-1];

`ifdef NTT_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
    end else if (state == ST_IDLE && start) begin
      cycle_count <= '0;
    end else if (state == ST_ISSUE || state == ST_DRAIN) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ntt_stage_scheduler.md
# ntt_stage_scheduler

Sequencing controller for a single pipelined butterfly unit and a dual-port coefficient memory. On `start` it walks every NTT stage (Cooley-Tukey forward, Gentleman-Sande inverse) or one element-wise pass. Each cycle it issues the read addresses, twiddle address and butterfly mode controls. It delays the addresses so they arrive at the write port together with the butterfly results, and it drains the pipeline between stages to satisfy the data dependences.

## Interface
- `LOG_N`, 10, log2 of polynomial length N (N = 1<<LOG_N)
- `BFU_LATENCY`, 17, cycles from butterfly operand input to registered result
- `MEM_RD_LATENCY`, 1, cycles from `rd_en` to data at butterfly input
- `clk`  in  1  clock; all logic is rising-edge
- `rst`  in  1  reset; asynchronous assertion, active-low
- `start`  in  1  one-cycle request; sampled only in IDLE
- `mode`  in  2  0 forward NTT, 1 inverse NTT, 2 element-wise multiply, 3 reserved (treated as 2); latched at start
- `busy`  out  1  high from the cycle after accepted start through the `done` cycle
- `done`  out  1  one-cycle pulse after the final write
- `rd_en`  out  1  read issue strobe
- `rd_addr_a`, `rd_addr_b`  out  LOG_N  operand addresses
- `tw_addr`  out  LOG_N  twiddle ROM index (bit-reversed power table)
- `bfu_forward`, `bfu_element_wise`  out  1  butterfly mode controls; held for the whole operation
- `wr_en_a`, `wr_en_b`  out  1  write strobes
- `wr_addr_a`, `wr_addr_b`  out  LOG_N  write addresses

## Operation
- Definitions: P = MEM_RD_LATENCY + BFU_LATENCY; k is the issue index within a pass.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: `start` is accepted. The block latches `mode`, clears the stage counter s and k, and goes to ISSUE. `start` in any other state is ignored.
- ISSUE: `rd_en`=1 every cycle. k counts 0..N/2-1 for NTT modes and 0..N-1 for element-wise. After the last k the block goes to DRAIN.
- Forward stage s: t = N>>(s+1), j = k>>(LOG_N-1-s), i = k&(t-1). Outputs: a = (j<<(LOG_N-s))+i, b = a+t, tw = (1<<s)+j.
- Inverse stage s: t = 1<<s, j = k>>s, i = k&(t-1). Outputs: a = (j<<(s+1))+i, b = a+t, tw = (N>>(s+1))+j.
- Element-wise: a = b = k, tw = 0. Only `wr_en_b` is used.
- `bfu_forward` = (mode==0 or element-wise). `bfu_element_wise` = element-wise.
- A delay line of depth P carries the valid bit and addresses a/b. Its output drives `wr_en_*` and `wr_addr_*`. `wr_en_a` and `wr_en_b` are both set for NTT modes.
- DRAIN: waits until the last write of the pass has been emitted. Then, if s < LOG_N-1, it increments s, clears k and returns to ISSUE. Otherwise it goes to FINISH.
- FINISH: pulses `done` and returns to IDLE.
- Arithmetic is unsigned and address math is modulo N; no computed address exceeds N-1.
- Reset, including mid-operation, returns to IDLE, clears the delay line, and drives every output to 0. No write is emitted after reset.

## Timing
- Accepted start is at cycle 0. The first `rd_en` is at cycle 1.
- Write for an issue at cycle c: `wr_en_*` at cycle c+P.
- Each NTT stage occupies N/2+P cycles. Stage s+1 issues in the cycle after stage s's last write.
- Final write: LOG_N·(N/2+P) for NTT, N+P for element-wise. `done` follows one cycle later; `busy` falls the cycle after `done`.
- Reset values: all outputs 0.
- `bfu_*` keep their last value in IDLE until the next accepted start.

## Configuration
- `NTT_SCHED_PERF_CNT_EN` defined: adds output `cycle_count` (32 bits). It clears on accepted start, increments every busy cycle, freezes at `done`, and is reset to 0.
- Not defined: no port and no counter logic.

## Structure
- Shared package `ntt_sched_pkg` holds:
  - the mode encoding constants;
  - the state enum typedef;
  - the helper for P.
- One sub-module, `ntt_addr_gen`, is natural: a combinational (s, k, mode) → (a, b, tw) mapper.
- The delay line stays inline.

## Test plan
Common settings for all scenarios: LOG_N=3, BFU_LATENCY=17, MEM_RD_LATENCY=1 (P=18).
- Forward run:
  - stage 0 issues (a,b,tw) = (0,4,1) (1,5,1) (2,6,1) (3,7,1);
  - stage 1 issues (0,2,2) (1,3,2) (4,6,3) (5,7,3);
  - stage 2 issues (2k,2k+1,4+k).
- Inverse run:
  - stage 0 issues (2k,2k+1,4+k);
  - stage 2 issues (k,k+4,1);
  - `bfu_forward`=0 throughout.
- Forward-run timing:
  - `done` at cycle 67;
  - writes mirror the reads 18 cycles later;
  - no `rd_en` during cycles 5–22.
- Element-wise run:
  - reads at k=0..7 during cycles 1–8;
  - `wr_en_b` only, at cycles 19–26;
  - `done` at cycle 27.
- `start` pulsed while busy: ignored, with no change to the address sequence or `done` time.
- Reset asserted at cycle 30 of a forward run: all outputs are 0 immediately, no further writes occur, and a new start then completes normally.
